// File: rtl/dqsw_training_ctrl.sv
// dqsw_training_ctrl: sweeps the DQSW IOD delay line, finds the early-to-late transition and backs off a fixed number of taps
module dqsw_training_ctrl #(
  parameter int TAP_W = 7,
  parameter int MAX_TAP = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int BACKOFF_TAPS = 2
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [1:0]       FAIL_CODE,
  output logic [TAP_W-1:0] TAP_VALUE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_EVAL, S_STEP, S_BACKOFF, S_DONE, S_FAIL
  } state_t;
  state_t state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d, rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic dir_q, dir_d, early_q, early_d, late_q, late_d, eph_q, eph_d, move, bo_ok;
  assign bo_ok = int'(tap_q) >= BACKOFF_TAPS;
  assign BUSY = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign DONE = state_q == S_DONE;
  assign FAIL = state_q == S_FAIL;
  assign FAIL_CODE = code_q;
  assign TAP_VALUE = tap_q;
  assign DELAY_LINE_LOAD = state_q == S_LOAD;
  assign DELAY_LINE_MOVE = move;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = state_q == S_CLEAR;
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    rem_d = rem_q;
    dir_d = dir_q;
    code_d = code_q;
    early_d = early_q;
    late_d = late_q;
    eph_d = eph_q;
    move = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        dir_d = (state_q == S_DONE) ? 1'b1 : dir_q;
        if (START) begin
          state_d = S_LOAD;
          code_d = 2'b00;
          eph_d = 1'b0;
        end
      end
      S_LOAD: begin
        tap_d = '0;
        dir_d = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: state_d = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? S_CLEAR : S_SETTLE;
      S_CLEAR: begin
        early_d = 1'b0;
        late_d = 1'b0;
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        early_d = early_q | EYE_MONITOR_EARLY;
        late_d = late_q | EYE_MONITOR_LATE;
        state_d = (cnt_q == 8'(SAMPLE_CYCLES - 1)) ? S_EVAL : S_SAMPLE;
      end
      S_EVAL: begin
        eph_d = eph_q | (early_q & ~late_q);
        if (late_q && !early_q && eph_q) begin
          state_d = bo_ok ? S_BACKOFF : S_FAIL;
          code_d = bo_ok ? 2'b00 : 2'b11;
          rem_d = TAP_W'(BACKOFF_TAPS);
        end else if (tap_q == TAP_W'(MAX_TAP)) begin
          state_d = S_FAIL;
          code_d = 2'b01;
        end else
          state_d = S_STEP;
      end
      S_STEP: begin
        move = 1'b1;
        tap_d = tap_q + 1'b1;
        state_d = S_SETTLE;
      end
      S_BACKOFF: begin
        if (rem_q == '0)
          state_d = S_DONE;
        else if (!cnt_q[0])
          dir_d = 1'b0;
        else begin
          move = 1'b1;
          tap_d = tap_q - 1'b1;
          rem_d = rem_q - 1'b1;
          state_d = (rem_q == TAP_W'(1)) ? S_DONE : S_BACKOFF;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (DELAY_LINE_OUT_OF_RANGE && BUSY && state_q != S_LOAD) begin
      state_d = S_FAIL;
      code_d = 2'b10;
      move = 1'b0;
      tap_d = tap_q;
      rem_d = rem_q;
    end
    cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge FAB_CLK)
    if (SYNC_RST) begin
      state_q <= S_IDLE;
      tap_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      code_q <= '0;
      dir_q <= 1'b0;
      early_q <= 1'b0;
      late_q <= 1'b0;
      eph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      dir_q <= dir_d;
      early_q <= early_d;
      late_q <= late_d;
      eph_q <= eph_d;
    end
endmodule

// File: tb/tb_dqsw_training_ctrl.sv
// tb_dqsw_training_ctrl: table-driven and scoreboard checks of the DQSW training sequencer
module tb_dqsw_training_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, oor = 1'b0;
  logic [15:0] early_pat = '0, late_pat = '0;
  logic a_busy, a_done, a_fail, a_load, a_move, a_dir, a_clr;
  logic b_busy, b_done, b_fail, b_load, b_move, b_dir, b_clr;
  logic [1:0] a_code, b_code;
  logic [3:0] a_tap, b_tap;
  int n_tests = 0, n_fail = 0, b_dec = 0, b0 = 0;
  int exp_q[$], obs_q[$];
  typedef struct {
    logic [15:0] early;
    logic [15:0] late;
    int done;
    int fail;
    int code;
    int tap;
    int n_inc;
    int n_dec;
  } vec_t;
  vec_t vecs[3];
  always #5 clk = ~clk;
  dqsw_training_ctrl #(.TAP_W(4), .MAX_TAP(15), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4), .BACKOFF_TAPS(2)) dut_a (
    .FAB_CLK(clk), .SYNC_RST(rst), .START(start), .BUSY(a_busy), .DONE(a_done), .FAIL(a_fail),
    .FAIL_CODE(a_code), .TAP_VALUE(a_tap), .DELAY_LINE_LOAD(a_load), .DELAY_LINE_MOVE(a_move),
    .DELAY_LINE_DIRECTION(a_dir), .EYE_MONITOR_CLEAR_FLAGS(a_clr), .EYE_MONITOR_EARLY(early_pat[a_tap]),
    .EYE_MONITOR_LATE(late_pat[a_tap]), .DELAY_LINE_OUT_OF_RANGE(oor));
  dqsw_training_ctrl #(.TAP_W(4), .MAX_TAP(15), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4), .BACKOFF_TAPS(3)) dut_b (
    .FAB_CLK(clk), .SYNC_RST(rst), .START(start), .BUSY(b_busy), .DONE(b_done), .FAIL(b_fail),
    .FAIL_CODE(b_code), .TAP_VALUE(b_tap), .DELAY_LINE_LOAD(b_load), .DELAY_LINE_MOVE(b_move),
    .DELAY_LINE_DIRECTION(b_dir), .EYE_MONITOR_CLEAR_FLAGS(b_clr), .EYE_MONITOR_EARLY(early_pat[b_tap]),
    .EYE_MONITOR_LATE(late_pat[b_tap]), .DELAY_LINE_OUT_OF_RANGE(oor));
  always @(negedge clk) begin
    if (!rst && a_move) obs_q.push_back(int'(a_dir) * 16 + int'(a_tap));
    if (!rst && b_move && !b_dir) b_dec = b_dec + 1;
  end
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push_moves(int n_inc, int n_dec);
    for (int i = 0; i < n_inc; i++) exp_q.push_back(16 + i);
    for (int j = 0; j < n_dec; j++) exp_q.push_back(n_inc - j);
  endtask
  task automatic drain(string name);
    chk({name, "_move_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk({name, "_move_dir_tap"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic kick(string name);
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk({name, "_load_before_accept"}, int'(a_load), 0);
    @(posedge clk);
    #1 start = 1'b0;
    chk({name, "_load_after_accept"}, int'(a_load), 1);
    chk({name, "_done_cleared"}, int'(a_done), 0);
    chk({name, "_fail_cleared"}, int'(a_fail), 0);
    chk({name, "_code_cleared"}, int'(a_code), 0);
    chk({name, "_busy"}, int'(a_busy), 1);
  endtask
  task automatic wait_idle(string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((a_done || a_fail) && (b_done || b_fail)) return;
    end
    chk({name, "_finish_timeout"}, 1, 0);
  endtask
  initial begin
    vecs[0] = '{16'h003F, 16'hFFC0, 1, 0, 0, 4, 6, 2};
    vecs[1] = '{16'hFFFF, 16'h0000, 0, 1, 1, 15, 15, 0};
    vecs[2] = '{16'h0002, 16'hFFFD, 1, 0, 0, 0, 2, 2};
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", int'({a_busy, a_done, a_fail, a_code, a_tap, a_load, a_move, a_dir, a_clr}), 0);
    rst = 1'b0;
    foreach (vecs[k]) begin
      b0 = b_dec;
      early_pat = vecs[k].early;
      late_pat = vecs[k].late;
      push_moves(vecs[k].n_inc, vecs[k].n_dec);
      kick($sformatf("vec%0d", k));
      wait_idle($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_done", k), int'(a_done), vecs[k].done);
      chk($sformatf("vec%0d_fail", k), int'(a_fail), vecs[k].fail);
      chk($sformatf("vec%0d_code", k), int'(a_code), vecs[k].code);
      chk($sformatf("vec%0d_tap", k), int'(a_tap), vecs[k].tap);
      chk($sformatf("vec%0d_busy", k), int'(a_busy), 0);
      drain($sformatf("vec%0d", k));
    end
    chk("bo3_fail", int'(b_fail), 1);
    chk("bo3_code", int'(b_code), 3);
    chk("bo3_tap", int'(b_tap), 2);
    chk("bo3_no_decrement", b_dec - b0, 0);
    early_pat = 16'hFFFF;
    late_pat = 16'h0000;
    push_moves(3, 0);
    kick("oor");
    for (int i = 0; i < 500 && !(a_clr && a_tap == 4'd3); i++) @(negedge clk);
    chk("oor_reached_tap3", int'(a_clr && a_tap == 4'd3), 1);
    @(posedge clk);
    #1 oor = 1'b1;
    @(posedge clk);
    #1 oor = 1'b0;
    @(negedge clk);
    chk("oor_fail", int'(a_fail), 1);
    chk("oor_code", int'(a_code), 2);
    chk("oor_tap", int'(a_tap), 3);
    chk("oor_move", int'(a_move), 0);
    chk("oor_busy", int'(a_busy), 0);
    wait_idle("oor");
    repeat (5) @(negedge clk);
    chk("oor_tap_frozen", int'(a_tap), 3);
    drain("oor");
    push_moves(4, 0);
    kick("rst_mid");
    for (int i = 0; i < 500 && !(a_move && a_tap == 4'd3); i++) @(negedge clk);
    chk("rst_reached_step3", int'(a_move && a_tap == 4'd3), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_outputs", int'({a_busy, a_done, a_fail, a_code, a_tap, a_load, a_move, a_dir, a_clr}), 0);
    repeat (4) @(negedge clk);
    chk("rst_idle_no_load", int'({a_busy, a_load}), 0);
    drain("rst_mid");
    early_pat = 16'h003F;
    late_pat = 16'hFFC0;
    push_moves(6, 2);
    kick("resweep");
    chk("resweep_tap0", int'(a_tap), 0);
    wait_idle("resweep");
    chk("resweep_done", int'(a_done), 1);
    chk("resweep_tap", int'(a_tap), 4);
    drain("resweep");
    push_moves(6, 2);
    kick("restart_busy");
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("restart_busy");
    chk("restart_busy_done", int'(a_done), 1);
    chk("restart_busy_tap", int'(a_tap), 4);
    chk("restart_busy_dir", int'(a_dir), 1);
    drain("restart_busy");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
